// File: rtl/ofdm_rx_pkg.sv
// Shared OFDM receive constants and types: default bin map and the demapper FSM state.
package ofdm_rx_pkg;

  localparam int unsigned DefNFft         = 64;
  localparam int unsigned DefFirstSc      = 4;
  localparam int unsigned DefLastSc       = 59;
  localparam int unsigned DefPilotSpacing = 7;

  localparam int unsigned BinW = $clog2(DefNFft);

  typedef enum logic [0:0] {
    StIdle,
    StActive
  } state_e;

endpackage

// File: rtl/qpsk_bin_classifier.sv
// Tracks the bin index within an OFDM symbol and classifies the current beat as
// guard, pilot or data. Pilot position uses an incremental phase counter, not a divider.
module qpsk_bin_classifier #(
  parameter int unsigned N_FFT         = 64,
  parameter int unsigned FIRST_SC      = 4,
  parameter int unsigned LAST_SC       = 59,
  parameter int unsigned PILOT_SPACING = 7
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic accept_i,
  input  logic sof_i,
  output logic is_data_o,
  output logic is_pilot_o,
  output logic is_last_o,
  output logic early_sof_o
);

  localparam int unsigned BinW = (N_FFT > 1) ? $clog2(N_FFT) : 1;
  localparam int unsigned PhW  = $clog2(PILOT_SPACING + 1);

  logic [BinW-1:0] bin_cnt_q, bin_cnt_d;
  logic [BinW-1:0] k, k_next;
  logic [PhW-1:0]  phase_q, phase_d, phase_cur;
  logic            in_range;

  always_comb begin
    // An sof beat is always bin 0, regardless of where the counter was.
    k           = sof_i ? '0 : bin_cnt_q;
    in_range    = (k >= BinW'(FIRST_SC)) && (k <= BinW'(LAST_SC));
    phase_cur   = (k == BinW'(FIRST_SC)) ? '0 : phase_q;
    is_pilot_o  = in_range && (phase_cur == '0);
    is_data_o   = in_range && !is_pilot_o;
    is_last_o   = (k == BinW'(N_FFT - 1));
    early_sof_o = accept_i && sof_i && (bin_cnt_q != '0);
    k_next      = is_last_o ? '0 : k + 1'b1;

    bin_cnt_d = bin_cnt_q;
    phase_d   = phase_q;
    if (accept_i) begin
      bin_cnt_d = k_next;
      if (k_next == BinW'(FIRST_SC)) begin
        phase_d = '0;
      end else if (in_range) begin
        phase_d = (phase_cur == PhW'(PILOT_SPACING - 1)) ? '0 : phase_cur + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bin_cnt_q <= '0;
      phase_q   <= '0;
    end else begin
      bin_cnt_q <= bin_cnt_d;
      phase_q   <= phase_d;
    end
  end

endmodule

// File: rtl/qpsk_demapper.sv
// Hard-decision QPSK demapper: drops guard/pilot bins, emits 2-bit symbols for data bins.
// Optional pilot sign-error counter enabled by QPSK_DEMAP_PILOT_CHECK_EN.
module qpsk_demapper
  import ofdm_rx_pkg::*;
#(
  parameter int unsigned DATA_W        = 16,
  parameter int unsigned N_FFT         = DefNFft,
  parameter int unsigned FIRST_SC      = DefFirstSc,
  parameter int unsigned LAST_SC       = DefLastSc,
  parameter int unsigned PILOT_SPACING = DefPilotSpacing
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fft_valid,
  input  logic              fft_sof,
  input  logic [DATA_W-1:0] fft_re,
  input  logic [DATA_W-1:0] fft_im,
  output logic [1:0]        out,
  output logic              demod_en,
  output logic              sym_done,
  output logic              frame_abort,
  output logic [15:0]       pilot_err_cnt
);

  state_e     state_q, state_d;
  logic       accept;
  logic       is_data, is_pilot, is_last, early_sof;
  logic [1:0] out_q, out_d;
  logic       demod_en_q, demod_en_d;
  logic       sym_done_q, sym_done_d;
  logic       frame_abort_q, frame_abort_d;

  // In IDLE only an sof beat is accepted; once ACTIVE every valid beat is a bin.
  assign accept = fft_valid && ((state_q == StActive) || fft_sof);

  qpsk_bin_classifier #(
    .N_FFT        (N_FFT),
    .FIRST_SC     (FIRST_SC),
    .LAST_SC      (LAST_SC),
    .PILOT_SPACING(PILOT_SPACING)
  ) u_classifier (
    .clk_i      (clk),
    .rst_ni     (reset),
    .accept_i   (accept),
    .sof_i      (fft_sof),
    .is_data_o  (is_data),
    .is_pilot_o (is_pilot),
    .is_last_o  (is_last),
    .early_sof_o(early_sof)
  );

  always_comb begin
    state_d       = state_q;
    out_d         = out_q;
    demod_en_d    = 1'b0;
    sym_done_d    = accept && is_last;
    frame_abort_d = early_sof;
    unique case (state_q)
      StIdle:   if (accept) state_d = StActive;
      StActive: state_d = StActive;
      default:  state_d = StIdle;
    endcase
    if (accept && is_data) begin
      demod_en_d = 1'b1;
      out_d      = {fft_im[DATA_W-1], fft_re[DATA_W-1]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      out_q         <= 2'b00;
      demod_en_q    <= 1'b0;
      sym_done_q    <= 1'b0;
      frame_abort_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      out_q         <= out_d;
      demod_en_q    <= demod_en_d;
      sym_done_q    <= sym_done_d;
      frame_abort_q <= frame_abort_d;
    end
  end

  assign out         = out_q;
  assign demod_en    = demod_en_q;
  assign sym_done    = sym_done_q;
  assign frame_abort = frame_abort_q;

`ifdef QPSK_DEMAP_PILOT_CHECK_EN
  logic [15:0] pilot_err_q;

  // Pilots are BPSK +1, so a negative real part is a sign error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pilot_err_q <= 16'h0000;
    end else if (accept && is_pilot && fft_re[DATA_W-1] && (pilot_err_q != 16'hFFFF)) begin
      pilot_err_q <= pilot_err_q + 16'd1;
    end
  end

  assign pilot_err_cnt = pilot_err_q;
`else
  logic unused_pilot;
  assign unused_pilot  = is_pilot;
  assign pilot_err_cnt = 16'h0000;
`endif

  logic unused_lsbs;
  assign unused_lsbs = ^{fft_re[DATA_W-2:0], fft_im[DATA_W-2:0]};

endmodule

// File: tb/tb_qpsk_demapper.sv
// Self-checking bench for qpsk_demapper: randomized beats checked against a bin-map model.
module tb_qpsk_demapper;

  localparam int DATA_W   = 16;
  localparam int N_FFT    = 64;
  localparam int FIRST_SC = 4;
  localparam int LAST_SC  = 59;
  localparam int PSP      = 7;
`ifdef QPSK_DEMAP_PILOT_CHECK_EN
  localparam int ExpPilotErr = 6;
`else
  localparam int ExpPilotErr = 0;
`endif

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic                     fft_valid = 1'b0;
  logic                     fft_sof = 1'b0;
  logic signed [DATA_W-1:0] fft_re = '0;
  logic signed [DATA_W-1:0] fft_im = '0;
  logic [1:0]               out;
  logic                     demod_en, sym_done, frame_abort;
  logic [15:0]              pilot_err_cnt;

  always #5 clk = ~clk;

  qpsk_demapper dut (
    .clk          (clk),
    .reset        (reset),
    .fft_valid    (fft_valid),
    .fft_sof      (fft_sof),
    .fft_re       (fft_re),
    .fft_im       (fft_im),
    .out          (out),
    .demod_en     (demod_en),
    .sym_done     (sym_done),
    .frame_abort  (frame_abort),
    .pilot_err_cnt(pilot_err_cnt)
  );

  int checks = 0;
  int failures = 0;
  int obs_en = 0, obs_done = 0, obs_abort = 0;

  // Reference model state
  bit         m_active;
  int         m_bin;
  logic [1:0] m_out;
  int         m_perr;
  logic       e_en, e_done, e_abort;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // 0 = guard, 1 = pilot, 2 = data
  function automatic int bin_class(input int k);
    if (k < FIRST_SC || k > LAST_SC) return 0;
    if ((k - FIRST_SC) % PSP == 0) return 1;
    return 2;
  endfunction

  task automatic model_reset();
    m_active = 0;
    m_bin    = 0;
    m_out    = 2'b00;
    m_perr   = 0;
    e_en     = 0;
    e_done   = 0;
    e_abort  = 0;
  endtask

  task automatic model_step(input bit v, input bit s, input logic signed [DATA_W-1:0] re,
                            input logic signed [DATA_W-1:0] im);
    int k;
    e_en    = 0;
    e_done  = 0;
    e_abort = 0;
    if (!v || (!m_active && !s)) return;
    k = m_bin;
    if (s) begin
      if (m_active && m_bin != 0) e_abort = 1;
      k = 0;
    end
    m_active = 1;
    case (bin_class(k))
      2: begin
        e_en  = 1;
        m_out = {im < 0, re < 0};
      end
      1: if (re < 0 && m_perr < 65535) m_perr++;
      default: ;
    endcase
    if (k == N_FFT - 1) begin
      e_done = 1;
      m_bin  = 0;
    end else begin
      m_bin = k + 1;
    end
  endtask

  task automatic beat(input bit v, input bit s, input logic signed [DATA_W-1:0] re,
                      input logic signed [DATA_W-1:0] im);
    fft_valid = v;
    fft_sof   = s;
    fft_re    = re;
    fft_im    = im;
    @(posedge clk);
    model_step(v, s, re, im);
    #1;
    obs_en    += int'(demod_en);
    obs_done  += int'(sym_done);
    obs_abort += int'(frame_abort);
    check("demod_en", 32'(demod_en), 32'(e_en));
    check("out", 32'(out), 32'(m_out));
    check("sym_done", 32'(sym_done), 32'(e_done));
    check("frame_abort", 32'(frame_abort), 32'(e_abort));
`ifdef QPSK_DEMAP_PILOT_CHECK_EN
    check("pilot_err_cnt", 32'(pilot_err_cnt), 32'(m_perr));
`else
    check("pilot_err_cnt", 32'(pilot_err_cnt), 32'd0);
`endif
    fft_valid = 0;
    fft_sof   = 0;
  endtask

  function automatic logic signed [DATA_W-1:0] rnd_val();
    if ($urandom_range(0, 7) == 0) return '0;
    return DATA_W'($urandom);
  endfunction

  // mode 0: re=+100 im=-100; mode 1: random; mode 2: pilots 11 and 46 negative
  task automatic send_bins(input bit first_sof, input int n, input bit gaps, input int mode);
    logic signed [DATA_W-1:0] re, im;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        while ($urandom_range(0, 2) == 0) beat(0, 0, rnd_val(), rnd_val());
      end
      case (mode)
        0: begin re = 100; im = -100; end
        1: begin re = rnd_val(); im = rnd_val(); end
        default: begin
          re = (i == 11 || i == 46) ? -16'sd100 : 16'sd100;
          im = rnd_val();
        end
      endcase
      beat(1, first_sof && (i == 0), re, im);
    end
  endtask

  initial begin
    model_reset();
    #2 reset = 0;
    #1;
    check("reset_demod_en", 32'(demod_en), 32'd0);
    check("reset_out", 32'(out), 32'd0);
    check("reset_sym_done", 32'(sym_done), 32'd0);
    check("reset_frame_abort", 32'(frame_abort), 32'd0);
    check("reset_pilot_err", 32'(pilot_err_cnt), 32'd0);
    repeat (3) @(posedge clk);
    #2 reset = 1;

    // Beats before any sof are ignored
    obs_en = 0;
    for (int i = 0; i < 20; i++) beat(1, 0, rnd_val(), rnd_val());
    check("pre_sof_pulses", 32'(obs_en), 32'd0);

    // One clean symbol
    obs_en = 0; obs_done = 0;
    send_bins(1, 64, 0, 0);
    check("sym1_pulses", 32'(obs_en), 32'd48);
    check("sym1_done", 32'(obs_done), 32'd1);
    check("sym1_out_hold", 32'(out), 32'h2);

    // Back-to-back symbol, no sof, random gaps
    send_bins(0, 64, 1, 1);
    check("two_sym_pulses", 32'(obs_en), 32'd96);
    check("two_sym_done", 32'(obs_done), 32'd2);

    // Early sof at bin 40, then a full symbol
    obs_abort = 0;
    send_bins(1, 40, 1, 1);
    obs_en = 0; obs_done = 0;
    send_bins(1, 64, 1, 1);
    check("abort_count", 32'(obs_abort), 32'd1);
    check("after_abort_pulses", 32'(obs_en), 32'd48);
    check("after_abort_done", 32'(obs_done), 32'd1);

    // Reset mid-symbol after bin 30
    send_bins(1, 31, 0, 1);
    reset = 0;
    #1;
    model_reset();
    check("midrst_demod_en", 32'(demod_en), 32'd0);
    check("midrst_out", 32'(out), 32'd0);
    check("midrst_sym_done", 32'(sym_done), 32'd0);
    check("midrst_frame_abort", 32'(frame_abort), 32'd0);
    check("midrst_pilot_err", 32'(pilot_err_cnt), 32'd0);
    repeat (2) @(posedge clk);
    #2 reset = 1;

    // Three pilot-error symbols after reset
    obs_en = 0; obs_done = 0; obs_abort = 0;
    send_bins(1, 64, 0, 2);
    check("post_rst_pulses", 32'(obs_en), 32'd48);
    send_bins(0, 64, 1, 2);
    send_bins(0, 64, 0, 2);
    check("pilot_pulses", 32'(obs_en), 32'd144);
    check("pilot_done", 32'(obs_done), 32'd3);
    check("pilot_abort", 32'(obs_abort), 32'd0);
    check("pilot_err_final", 32'(pilot_err_cnt), 32'(ExpPilotErr));

    // Trailing stalls must produce nothing
    obs_en = 0;
    for (int i = 0; i < 5; i++) beat(0, 1, rnd_val(), rnd_val());
    check("stall_pulses", 32'(obs_en), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
